// File: rtl/tetris_pkg.sv
// Shared piece definitions and scheduler state type for the piece dealing logic.
package tetris_pkg;

  localparam int PIECE_W = 3;

  typedef logic [PIECE_W-1:0] piece_t;

  localparam piece_t PIECE_I    = 3'd0;
  localparam piece_t PIECE_O    = 3'd1;
  localparam piece_t PIECE_T    = 3'd2;
  localparam piece_t PIECE_S    = 3'd3;
  localparam piece_t PIECE_Z    = 3'd4;
  localparam piece_t PIECE_J    = 3'd5;
  localparam piece_t PIECE_L    = 3'd6;
  localparam piece_t PIECE_NONE = 3'd7;

  // INIT: queue still filling after reset, nothing dealable. RUN: dealing.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

endpackage

// File: rtl/piece_fifo.sv
// Shift-register piece queue. Slot 0 is the head; popped entries shift toward
// the head and vacated slots are refilled with zero. The next-state head,
// second slot and count are exported so the owner can register its outputs
// from them without adding a cycle of latency.
module piece_fifo
  import tetris_pkg::*;
#(
  parameter int QDEPTH = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  piece_t     din,
  output piece_t     head_nxt,
  output piece_t     second_nxt,
  output logic [2:0] count,
  output logic [2:0] count_nxt
);

  localparam logic [2:0] DEPTH = 3'(QDEPTH);

  piece_t q     [QDEPTH];
  piece_t q_nxt [QDEPTH];

  // Pop first (shift toward head), then write the new code into the first free
  // slot, so a simultaneous push and pop lands in the freed tail.
  always_comb begin
    for (int i = 0; i < QDEPTH; i++) q_nxt[i] = q[i];
    count_nxt = count;
    if (pop && (count != 3'd0)) begin
      for (int i = 0; i < QDEPTH - 1; i++) q_nxt[i] = q[i + 1];
      q_nxt[QDEPTH - 1] = '0;
      count_nxt = count - 3'd1;
    end
    if (push && (count_nxt < DEPTH)) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (3'(i) == count_nxt) q_nxt[i] = din;
      end
      count_nxt = count_nxt + 3'd1;
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
      count <= 3'd0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) q[i] <= q_nxt[i];
      count <= count_nxt;
    end
  end

  assign head_nxt   = q_nxt[0];
  assign second_nxt = q_nxt[1];

endmodule

// File: rtl/piece_scheduler.sv
// Piece scheduler: filters the free-running random code (optionally through a
// 7-bag fairness mask), queues accepted pieces and deals the head on request.
// Handshake: a pop happens on every edge where req=1 and piece_valid=1; req
// while piece_valid=0 is dropped and flagged by a one-cycle req_err pulse.
// All outputs are flops fed from next-state values, so nothing from random or
// req reaches an output combinationally.
module piece_scheduler
  import tetris_pkg::*;
#(
  parameter int QDEPTH = 3,
  parameter int BAG_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  piece_t     random,
  input  logic       req,
  output piece_t     piece,
  output logic       piece_valid,
  output piece_t     next_piece,
  output logic       next_valid,
  output logic [2:0] count,
  output logic       req_err
);

  localparam logic [2:0] DEPTH = 3'(QDEPTH);

  sched_state_t state, state_nxt;
  logic [6:0]   bag_mask, bag_nxt, bag_bit;
  logic         accept, push, pop;
  logic         pv_nxt, nv_nxt;
  piece_t       head_nxt, second_nxt;
  logic [2:0]   count_nxt;

  assign pop     = req & piece_valid;
  assign bag_bit = 7'd1 << random;

  // Filter and room check: a code is pushed only if legal, unused in the
  // current bag, and the queue has space after any same-cycle pop.
  always_comb begin
    accept = (random != PIECE_NONE) &&
             ((BAG_EN == 0) || ((bag_mask & bag_bit) == 7'd0));
    push   = accept && ((count != DEPTH) || pop);
  end

  // Bag history: mark each pushed code; a completed bag starts over empty.
  always_comb begin
    bag_nxt = bag_mask;
    if ((BAG_EN != 0) && push) begin
      bag_nxt = bag_mask | bag_bit;
      if (bag_nxt == 7'h7F) bag_nxt = 7'd0;
    end
  end

  piece_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .din        (random),
    .head_nxt   (head_nxt),
    .second_nxt (second_nxt),
    .count      (count),
    .count_nxt  (count_nxt)
  );

  // FSM next state and next-cycle validity: INIT until the queue first fills.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (count_nxt == DEPTH) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
    pv_nxt = (state_nxt == ST_RUN) && (count_nxt != 3'd0);
    nv_nxt = (state_nxt == ST_RUN) && (count_nxt >= 3'd2);
  end

  // State, bag history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      bag_mask    <= 7'd0;
      piece       <= '0;
      piece_valid <= 1'b0;
      next_piece  <= '0;
      next_valid  <= 1'b0;
      req_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      bag_mask    <= bag_nxt;
      piece       <= pv_nxt ? head_nxt : '0;
      piece_valid <= pv_nxt;
      next_piece  <= nv_nxt ? second_nxt : '0;
      next_valid  <= nv_nxt;
      req_err     <= req & ~piece_valid;
    end
  end

endmodule

// File: tb/tb_piece_scheduler.sv
// Bench for piece_scheduler: two instances (bag filter on and off) share the
// stimulus; a queue-based model of dealing rules predicts every output each
// cycle, and directed scenarios pin known results with literal values.
module tb_piece_scheduler;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] random = 3'd0;
  logic       req = 1'b0;

  always #5 clk = ~clk;

  logic [2:0] piece_o [2];
  logic       pv_o    [2];
  logic [2:0] next_o  [2];
  logic       nv_o    [2];
  logic [2:0] cnt_o   [2];
  logic       err_o   [2];

  piece_scheduler #(.QDEPTH(3), .BAG_EN(0)) dut_raw (
    .clk(clk), .rst_n(rst_n), .random(random), .req(req),
    .piece(piece_o[0]), .piece_valid(pv_o[0]), .next_piece(next_o[0]),
    .next_valid(nv_o[0]), .count(cnt_o[0]), .req_err(err_o[0]));

  piece_scheduler #(.QDEPTH(3), .BAG_EN(1)) dut_bag (
    .clk(clk), .rst_n(rst_n), .random(random), .req(req),
    .piece(piece_o[1]), .piece_valid(pv_o[1]), .next_piece(next_o[1]),
    .next_valid(nv_o[1]), .count(cnt_o[1]), .req_err(err_o[1]));

  // ---------------- scoreboard / model ----------------
  localparam int DEPTH = 3;
  int         total = 0;
  int         bad = 0;
  int         mq    [2][$];
  logic [6:0] mmask [2];
  bit         mrun  [2];
  bit         merr  [2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++) begin
      mq[b].delete();
      mmask[b] = 7'd0;
      mrun[b]  = 1'b0;
      merr[b]  = 1'b0;
    end
  endtask

  // One clock edge of the dealing rules for instance b (b=1 uses the bag).
  task automatic model_edge(input int b, input int r, input bit rq);
    bit dealable, acc;
    dealable = mrun[b] && (mq[b].size() > 0);
    merr[b]  = rq && !dealable;
    if (rq && dealable) void'(mq[b].pop_front());
    acc = (r != 7) && ((b == 0) || !mmask[b][r]);
    if (acc && (mq[b].size() < DEPTH)) begin
      mq[b].push_back(r);
      if (b == 1) begin
        mmask[b][r] = 1'b1;
        if (mmask[b] == 7'h7F) mmask[b] = 7'd0;
      end
    end
    if (mq[b].size() == DEPTH) mrun[b] = 1'b1;
  endtask

  // Compare every output of both instances against the model.
  task automatic compare_all();
    int  sz, ep, en;
    bit  v, nv;
    for (int b = 0; b < 2; b++) begin
      sz = mq[b].size();
      v  = mrun[b] && (sz > 0);
      nv = mrun[b] && (sz >= 2);
      ep = v  ? mq[b][0] : 0;
      en = nv ? mq[b][1] : 0;
      chk($sformatf("piece[%0d]", b),       piece_o[b], ep);
      chk($sformatf("piece_valid[%0d]", b), pv_o[b],    int'(v));
      chk($sformatf("next_piece[%0d]", b),  next_o[b],  en);
      chk($sformatf("next_valid[%0d]", b),  nv_o[b],    int'(nv));
      chk($sformatf("count[%0d]", b),       cnt_o[b],   sz);
      chk($sformatf("req_err[%0d]", b),     err_o[b],   int'(merr[b]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; drives inputs, takes one edge, checks at posedge+1.
  task automatic step(input int r, input bit rq);
    random = 3'(r);
    req    = rq;
    @(posedge clk);
    model_edge(0, r, rq);
    model_edge(1, r, rq);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    random = 3'd0;
    req = 1'b0;
    model_clear();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_clear();
    #2;
    do_reset();

    // Reset fill: 7 rejected, repeated 2 rejected by the bag.
    step(7, 0); step(2, 0); step(2, 0); step(5, 0);
    chk("fill_pv_before", pv_o[1], 0);
    chk("fill_cnt_before", cnt_o[1], 2);
    step(0, 0);
    chk("fill_piece", piece_o[1], 2);
    chk("fill_next", next_o[1], 5);
    chk("fill_count", cnt_o[1], 3);
    chk("fill_pv", pv_o[1], 1);

    // Full pop plus push.
    do_reset();
    step(1, 0); step(4, 0); step(6, 0);
    step(2, 1);
    chk("pp_piece", piece_o[1], 4);
    chk("pp_next", next_o[1], 6);
    chk("pp_count", cnt_o[1], 3);
    step(7, 1); step(7, 1);
    chk("pp_tail", piece_o[1], 2);

    // Bag completion: seventh push clears the mask, 3 then accepted again.
    do_reset();
    step(0, 0); step(1, 0); step(2, 0);
    step(3, 1); step(4, 1); step(5, 1); step(6, 1);
    step(3, 1);
    chk("bag_piece", piece_o[1], 5);
    chk("bag_next", next_o[1], 6);
    chk("bag_count", cnt_o[1], 3);
    step(7, 1);
    chk("bag_new_first", next_o[1], 3);

    // Underflow in INIT with one queued piece.
    do_reset();
    step(0, 0);
    step(7, 1);
    chk("uf_err", err_o[1], 1);
    chk("uf_count", cnt_o[1], 1);
    chk("uf_pv", pv_o[1], 0);
    step(7, 0);
    chk("uf_err_drop", err_o[1], 0);

    // Raw pass-through: 4,4,4 fills the unfiltered queue.
    do_reset();
    step(4, 0); step(4, 0); step(4, 0);
    chk("raw_count", cnt_o[0], 3);
    chk("raw_piece", piece_o[0], 4);
    chk("raw_next", next_o[0], 4);
    chk("raw_bag_count", cnt_o[1], 1);

    // Mid-run asynchronous reset between edges.
    do_reset();
    step(0, 0); step(1, 0); step(2, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr_piece", piece_o[1], 0);
    chk("mr_pv", pv_o[1], 0);
    chk("mr_next", next_o[1], 0);
    chk("mr_nv", nv_o[1], 0);
    chk("mr_count", cnt_o[1], 0);
    chk("mr_err", err_o[1], 0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0);
    chk("mr_refill", cnt_o[1], 1);
    step(1, 0); step(2, 0);
    chk("mr_refill_piece", piece_o[1], 0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      step(int'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
